// File: rtl/wb_master_cmd.sv
// wb_master_cmd: Wishbone classic initiator.
// Turns single-word commands from a valid/ready channel into Wishbone bus cycles
// and returns read data plus termination status on a valid/ready response channel.
// Terminations are ERR, ACK and RTY, with a bounded number of retries.
// Optional bus-wait timeout: define WB_MASTER_CMD_TIMEOUT_EN to build it.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. A valid, once raised, is held with
// stable payload until that edge. Ready never depends combinationally on valid.
module wb_master_cmd #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int RETRY_MAX      = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic                    cmd_we,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_status,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    output logic                    wbm_we_o,
    output logic [SELECT_WIDTH-1:0] wbm_sel_o,
    output logic                    wbm_stb_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i,
    output logic                    wbm_cyc_o,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS     = 2'd1,
        S_BACKOFF = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_ERR = 2'd1;
    localparam logic [1:0] ST_RTY = 2'd2;
    localparam logic [1:0] ST_TMO = 2'd3;

    // Retry counter must hold 0..RETRY_MAX, and is at least one bit wide.
    localparam int RCW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    we_q, we_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]              rsp_status_q, rsp_status_d;
    logic [RCW-1:0]          retry_cnt_q, retry_cnt_d;
    logic                    tmo_hit;

`ifdef WB_MASTER_CMD_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Last permitted wait cycle of the current bus attempt.
    assign tmo_hit = (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

    // Bus-wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    // Never true: no timeout logic is built, so the bus waits indefinitely.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    // State, bus and response registers; reset drops cyc/stb at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            retry_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end

    // Next-state and next-output logic for the command/bus/response sequence.
    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        we_d         = we_q;
        sel_d        = sel_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        retry_cnt_d  = retry_cnt_q;
`ifdef WB_MASTER_CMD_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    adr_d       = cmd_addr;
                    dat_d       = cmd_data;
                    we_d        = cmd_we;
                    sel_d       = cmd_sel;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    retry_cnt_d = '0;
`ifdef WB_MASTER_CMD_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                    state_d     = S_BUS;
                end
            end

            S_BUS: begin
                // err beats ack beats rty when several arrive together.
                if (wbm_err_i) begin
                    rsp_data_d   = '0;
                    rsp_status_d = ST_ERR;
                    state_d      = S_RESP;
                end else if (wbm_ack_i) begin
                    rsp_data_d   = we_q ? '0 : wbm_dat_i;
                    rsp_status_d = ST_OK;
                    state_d      = S_RESP;
                end else if (wbm_rty_i) begin
                    if (retry_cnt_q < RCW'(RETRY_MAX)) begin
                        retry_cnt_d = retry_cnt_q + RCW'(1);
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        state_d     = S_BACKOFF;
                    end else begin
                        rsp_data_d   = '0;
                        rsp_status_d = ST_RTY;
                        state_d      = S_RESP;
                    end
                end else if (tmo_hit) begin
                    rsp_data_d   = '0;
                    rsp_status_d = ST_TMO;
                    state_d      = S_RESP;
                end
`ifdef WB_MASTER_CMD_TIMEOUT_EN
                if (!wbm_err_i && !wbm_ack_i && !wbm_rty_i) begin
                    tmo_cnt_d = tmo_cnt_q + TCW'(1);
                end
`endif
                // Final termination: release the bus and present the response.
                if (state_d == S_RESP) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end

            S_BACKOFF: begin
                // One idle bus cycle, then re-issue the same transfer.
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
`ifdef WB_MASTER_CMD_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_BUS;
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered decodes of the next state.
    assign cmd_ready_d = (state_d == S_IDLE);
    assign busy_d      = (state_d != S_IDLE);

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign wbm_we_o   = we_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = stb_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_wb_master_cmd.sv
// Testbench for wb_master_cmd: directed scenarios followed by random commands.
// A scripted Wishbone slave answers each bus attempt from a plan; a plan-walking
// reference model predicts each response, and a monitor compares responses.
module tb_wb_master_cmd;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int RMAX = 3;
  localparam int TMO = 16;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_RTY    = 2;
  localparam int K_ERRACK = 3;
  localparam int K_RTYACK = 4;
  localparam int K_SILENT = 5;

  typedef struct {
    int kind;
    int waits;
    logic [DW-1:0] data;
  } att_t;

  logic clk;
  logic rst_n;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic cmd_we;
  logic [SW-1:0] cmd_sel;
  logic cmd_valid;
  logic cmd_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0] rsp_status;
  logic rsp_valid;
  logic rsp_ready;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_i;
  logic [DW-1:0] wbm_dat_o;
  logic wbm_we_o;
  logic [SW-1:0] wbm_sel_o;
  logic wbm_stb_o;
  logic wbm_ack_i;
  logic wbm_err_i;
  logic wbm_rty_i;
  logic wbm_cyc_o;
  logic busy;
  logic [1:0] dbg_state;

  wb_master_cmd #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .SELECT_WIDTH(SW),
    .RETRY_MAX(RMAX),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_we(cmd_we),
    .cmd_sel(cmd_sel),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_data(rsp_data),
    .rsp_status(rsp_status),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_dat_o(wbm_dat_o),
    .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i),
    .wbm_cyc_o(wbm_cyc_o),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [DW+1:0] exp_q[$];   // {status, data}
  att_t plan_q[$];           // attempts being assembled for the next command
  att_t att_q[$];            // attempts the slave still has to serve
  int hold_cnt = 0;

  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic cur_we;
  logic [SW-1:0] cur_sel;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: walk the slave's plan for one command.
  function automatic logic [DW+1:0] model(input logic we);
    int retries = 0;
    foreach (plan_q[i]) begin
      case (plan_q[i].kind)
        K_RTY: begin
          if (retries < RMAX) retries++;
          else return {2'd2, {DW{1'b0}}};
        end
        K_ACK, K_RTYACK: return {2'd0, (we ? {DW{1'b0}} : plan_q[i].data)};
        K_ERR, K_ERRACK: return {2'd1, {DW{1'b0}}};
        default: return {2'd3, {DW{1'b0}}};
      endcase
    end
    return {2'd3, {DW{1'b0}}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_att(input int kind, input int waits, input logic [DW-1:0] data);
    att_t a;
    a.kind = kind;
    a.waits = waits;
    a.data = data;
    plan_q.push_back(a);
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                       input logic [SW-1:0] s, input bit expect_rsp, input int hold);
    int n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    if (expect_rsp) exp_q.push_back(model(w));
    while (plan_q.size() != 0) att_q.push_back(plan_q.pop_front());
    hold_cnt = hold;
    cur_addr = a;
    cur_data = d;
    cur_we = w;
    cur_sel = s;
    cmd_addr = a;
    cmd_data = d;
    cmd_we = w;
    cmd_sel = s;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = $urandom;
    cmd_data = $urandom;
    check("first_cyc", wbm_cyc_o, 1);
    check("first_stb", wbm_stb_o, 1);
    check("first_adr", wbm_adr_o, a);
    check("first_we", wbm_we_o, w);
    check("ready_low_busy", cmd_ready, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_cyc", wbm_cyc_o, 0);
    check("post_rst_no_rsp", exp_q.size(), 0);
  endtask

  // ---------------- scripted slave ----------------
  att_t cur_att;
  bit att_active = 0;
  int wcnt = 0;
  bit prev_rty = 0;
  int low_cnt = 0;

  always @(negedge clk) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = $urandom;
    if (!rst_n) begin
      att_active = 0;
      att_q.delete();
      prev_rty = 0;
      low_cnt = 0;
    end else if (wbm_cyc_o) begin
      check("stb_with_cyc", wbm_stb_o, 1);
      check("adr_hold", wbm_adr_o, cur_addr);
      check("dat_hold", wbm_dat_o, cur_data);
      check("sel_hold", wbm_sel_o, cur_sel);
      check("we_hold", wbm_we_o, cur_we);
      if (!att_active) begin
        check("attempt_avail", att_q.size() != 0, 1);
        if (att_q.size() != 0) begin
          cur_att = att_q.pop_front();
          att_active = 1;
          wcnt = 0;
          if (prev_rty) check("backoff_gap", low_cnt, 1);
        end
      end
      if (att_active) begin
        if (cur_att.kind != K_SILENT && wcnt == cur_att.waits) begin
          case (cur_att.kind)
            K_ACK: wbm_ack_i = 1'b1;
            K_ERR: wbm_err_i = 1'b1;
            K_RTY: wbm_rty_i = 1'b1;
            K_ERRACK: begin wbm_err_i = 1'b1; wbm_ack_i = 1'b1; end
            default: begin wbm_rty_i = 1'b1; wbm_ack_i = 1'b1; end
          endcase
          wbm_dat_i = cur_att.data;
          prev_rty = (cur_att.kind == K_RTY) && (att_q.size() != 0);
          att_active = 0;
        end else begin
          wcnt++;
        end
      end
      low_cnt = 0;
    end else begin
      if (att_active) begin
        check("timeout_len", wcnt, TMO);
        att_active = 0;
        prev_rty = 0;
      end
      low_cnt++;
      if ($urandom_range(0, 3) == 0) begin
        wbm_ack_i = 1'($urandom_range(0, 1));
        wbm_err_i = 1'($urandom_range(0, 1));
        wbm_rty_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_ready = 1'b0;
    end else if (rsp_valid) begin
      check("rsp_expected", exp_q.size() != 0, 1);
      check("rsp_cmd_ready_low", cmd_ready, 0);
      check("rsp_busy", busy, 1);
      check("rsp_cyc_low", wbm_cyc_o, 0);
      check("rsp_we_low", wbm_we_o, 0);
      if (exp_q.size() != 0) begin
        check("rsp_status", rsp_status, exp_q[0][DW+1:DW]);
        check("rsp_data", rsp_data, exp_q[0][DW-1:0]);
      end
      if (hold_cnt > 0) begin
        rsp_ready = 1'b0;
        hold_cnt--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        check("attempts_used", att_q.size(), 0);
      end
    end else begin
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    cmd_we = 1'b0;
    cmd_sel = '0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = '0;
    cur_addr = '0;
    cur_data = '0;
    cur_we = 1'b0;
    cur_sel = '0;
    repeat (3) @(negedge clk);
    check("reset_cyc", wbm_cyc_o, 0);
    check("reset_stb", wbm_stb_o, 0);
    check("reset_adr", wbm_adr_o, 0);
    check("reset_dat", wbm_dat_o, 0);
    check("reset_we", wbm_we_o, 0);
    check("reset_sel", wbm_sel_o, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_status", rsp_status, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);

    // Write with two wait states.
    push_att(K_ACK, 2, $urandom);
    issue(32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 1, 0);

    // Read with five wait states, response held off for three cycles.
    push_att(K_ACK, 5, 32'h12345678);
    issue(32'h20, $urandom, 1'b0, 4'hF, 1, 3);

    // err and ack together: err wins.
    push_att(K_ERRACK, 1, 32'hCAFEF00D);
    issue($urandom, $urandom, 1'b0, 4'h3, 1, 0);

    // Two retries then ack.
    push_att(K_RTY, 0, '0);
    push_att(K_RTY, 1, '0);
    push_att(K_ACK, 0, 32'hA5);
    issue(32'h40, $urandom, 1'b0, 4'hF, 1, 0);

    // Four retries: exhausted.
    for (int i = 0; i < RMAX + 1; i++) push_att(K_RTY, i, '0);
    issue(32'h44, $urandom, 1'b1, 4'hC, 1, 0);

    // Silent slave.
    push_att(K_SILENT, 0, '0);
`ifdef WB_MASTER_CMD_TIMEOUT_EN
    issue(32'h80, $urandom, 1'b0, 4'hF, 1, 0);
`else
    issue(32'h80, $urandom, 1'b0, 4'hF, 0, 0);
    repeat (99) @(negedge clk);
    check("cyc_held_100", wbm_cyc_o, 1);
    pulse_reset();
`endif

    // Reset in the middle of a bus cycle, then a normal command.
    push_att(K_SILENT, 0, '0);
    issue(32'h90, $urandom, 1'b1, 4'hF, 0, 0);
    repeat (5) @(negedge clk);
    pulse_reset();
    push_att(K_ACK, 1, 32'h0BADCAFE);
    issue(32'h94, $urandom, 1'b0, 4'hF, 1, 0);

    // Random commands.
    for (int c = 0; c < 40; c++) begin
      int nr;
      nr = $urandom_range(0, RMAX + 1);
      if (nr > RMAX) begin
        for (int i = 0; i < RMAX + 1; i++) push_att(K_RTY, $urandom_range(0, 3), '0);
      end else begin
        int fk;
        for (int i = 0; i < nr; i++) push_att(K_RTY, $urandom_range(0, 3), '0);
        case ($urandom_range(0, 5))
          0: fk = K_ERR;
          1: fk = K_ERRACK;
          2: fk = K_RTYACK;
          default: fk = K_ACK;
        endcase
        push_att(fk, $urandom_range(0, 5), $urandom);
      end
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1,
            $urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Drain outstanding responses.
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
